// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control unit.
// Holds the FSM state enum, the opcode/funct3 constants, the mux select
// encodings and the packed control bundle driven by the output decoder.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  // result_src encodings
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // alu_src_a encodings
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // alu_op encodings
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Only beq/bne are supported branch flavours.
  function automatic logic branch_f3_legal(input logic [2:0] funct3);
    return (funct3 == F3Beq) || (funct3 == F3Bne);
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3Beq) && zero) || ((funct3 == F3Bne) && !zero);
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational control-output decoder for the multi-cycle control unit.
// Ports:
//   state_i     - current FSM state
//   mem_ready_i - memory handshake (gates PC/IR load in fetch)
//   zero_i      - ALU zero flag (branch resolution)
//   funct3_i    - branch polarity
//   ctrl_o      - packed strobes and mux selects
module mcu_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  input  logic [2:0]  funct3_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src_a  = SrcAPc;
        ctrl_o.alu_src_b  = SrcBFour;
        ctrl_o.alu_op     = AluAdd;
        ctrl_o.result_src = ResAluResult;
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.pc_en      = mem_ready_i;
      end
      StDecode: begin
        // Branch/jump target lands in ALUOut for later use.
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemRead: begin
        ctrl_o.adr_src  = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StMemWb: begin
        ctrl_o.result_src = ResMemData;
        ctrl_o.reg_write  = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.adr_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      StExecR: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluFunct;
      end
      StExecI: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluFunct;
      end
      StAluWb: begin
        ctrl_o.result_src = ResAluOut;
        ctrl_o.reg_write  = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a  = SrcARs1;
        ctrl_o.alu_src_b  = SrcBRs2;
        ctrl_o.alu_op     = AluSub;
        ctrl_o.result_src = ResAluOut;
        ctrl_o.pc_en      = branch_taken(funct3_i, zero_i);
      end
      StJal: begin
        // PC takes the target computed in decode; ALU forms oldPC + 4 for rd.
        ctrl_o.alu_src_a  = SrcAOldPc;
        ctrl_o.alu_src_b  = SrcBFour;
        ctrl_o.alu_op     = AluAdd;
        ctrl_o.result_src = ResAluOut;
        ctrl_o.pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM (R, I-ALU, lw, sw, beq/bne, jal).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   opcode, funct3      - fields from the instruction register
//   zero                - ALU zero flag
//   mem_ready           - memory access completes this cycle
//   pc_en ... alu_op    - datapath strobes and mux selects (all 0 in reset)
//   illegal_instr       - sticky illegal-opcode / bad-branch flag
//   retired             - retired-instruction count (wraps)
//   state_o             - current state, for debug
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit          SUPPORT_IALU = 1'b1,
  parameter bit          SUPPORT_JAL  = 1'b1,
  parameter int unsigned RET_CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 illegal_instr,
  output logic [RET_CNT_W-1:0] retired,
  output logic [3:0]           state_o
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [RET_CNT_W-1:0] retired_q, retired_d;
  logic                 retire;
  logic                 bad_branch;
  ctrl_t                ctrl, ctrl_gated;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    bad_branch = 1'b0;
    unique case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpImm:           state_d = SUPPORT_IALU ? StExecI : StTrap;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = SUPPORT_JAL ? StJal : StTrap;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:  state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: if (mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StAluWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch: begin
        state_d    = StFetch;
        retire     = branch_f3_legal(funct3);
        bad_branch = !branch_f3_legal(funct3);
      end
      StJal:     state_d = StAluWb;
      StTrap:    state_d = StTrap;
      // Unused encodings recover to fetch.
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | bad_branch | (state_q == StTrap);
    retired_d = retire ? retired_q + RET_CNT_W'(1) : retired_q;
  end

  mcu_output_decode u_output_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .funct3_i    (funct3),
    .ctrl_o      (ctrl)
  );

  // Reset forces fetch asynchronously; mask fetch's strobes/selects until release.
  always_comb begin
    ctrl_gated = reset ? '0 : ctrl;
  end

  always_comb begin
    pc_en         = ctrl_gated.pc_en;
    ir_write      = ctrl_gated.ir_write;
    adr_src       = ctrl_gated.adr_src;
    mem_read      = ctrl_gated.mem_read;
    mem_write     = ctrl_gated.mem_write;
    reg_write     = ctrl_gated.reg_write;
    result_src    = ctrl_gated.result_src;
    alu_src_a     = ctrl_gated.alu_src_a;
    alu_src_b     = ctrl_gated.alu_src_b;
    alu_op        = ctrl_gated.alu_op;
    // Flag is visible from the first trap cycle, not one cycle later.
    illegal_instr = illegal_q | (state_q == StTrap);
    retired       = retired_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference model drives
// phase sequences and checks every cycle's controls plus end-of-instruction state.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  localparam int PhFetch = 0, PhDecode = 1, PhMemAdr = 2, PhMemRead = 3, PhMemWb = 4;
  localparam int PhMemWrite = 5, PhExecR = 6, PhExecI = 7, PhAluWb = 8, PhBranch = 9;
  localparam int PhJal = 10, PhTrap = 11;
  localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KBr = 4, KJal = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic pc_en, ir_write, adr_src, mem_read, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [31:0] retired;
  logic [3:0] state_o;

  logic n_pc_en, n_ir_write, n_adr_src, n_mem_read, n_mem_write, n_reg_write, n_illegal;
  logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b, n_alu_op;
  logic [31:0] n_retired;
  logic [3:0] n_state;

  logic w_pc_en, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write, w_illegal;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
  logic [3:0] w_retired;
  logic [3:0] w_state;

  logic [13:0] vec, n_vec;
  assign vec = {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op};
  assign n_vec = {n_pc_en, n_ir_write, n_adr_src, n_mem_read, n_mem_write, n_reg_write,
                  n_result_src, n_alu_src_a, n_alu_src_b, n_alu_op};

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_instr(illegal_instr), .retired(retired), .state_o(state_o)
  );

  multicycle_control_unit #(.SUPPORT_JAL(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_en(n_pc_en), .ir_write(n_ir_write), .adr_src(n_adr_src),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .reg_write(n_reg_write),
    .result_src(n_result_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_op(n_alu_op), .illegal_instr(n_illegal), .retired(n_retired), .state_o(n_state)
  );

  multicycle_control_unit #(.RET_CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_en(w_pc_en), .ir_write(w_ir_write), .adr_src(w_adr_src),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_write(w_reg_write),
    .result_src(w_result_src), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
    .alu_op(w_alu_op), .illegal_instr(w_illegal), .retired(w_retired), .state_o(w_state)
  );

  int          passes = 0;
  int          total = 0;
  logic [31:0] exp_ret = '0;
  logic        exp_ill = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected controls for one cycle of a phase, straight from the control table.
  function automatic logic [13:0] phase_exp(input int ph, input logic mr, input logic z,
                                            input logic [2:0] f3);
    logic pc, ir, adr, mrd, mwr, rw;
    logic [1:0] rs, a, b, op;
    {pc, ir, adr, mrd, mwr, rw} = '0;
    {rs, a, b, op} = '0;
    case (ph)
      PhFetch:    begin mrd = 1; b = 2'b10; rs = 2'b10; pc = mr; ir = mr; end
      PhDecode:   begin a = 2'b01; b = 2'b01; end
      PhMemAdr:   begin a = 2'b10; b = 2'b01; end
      PhMemRead:  begin adr = 1; mrd = 1; end
      PhMemWb:    begin rs = 2'b01; rw = 1; end
      PhMemWrite: begin adr = 1; mwr = 1; end
      PhExecR:    begin a = 2'b10; op = 2'b10; end
      PhExecI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      PhAluWb:    begin rw = 1; end
      PhBranch:   begin a = 2'b10; op = 2'b01; pc = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
      PhJal:      begin a = 2'b01; b = 2'b10; pc = 1; end
      default:    ;
    endcase
    return {pc, ir, adr, mrd, mwr, rw, rs, a, b, op};
  endfunction

  function automatic logic [6:0] opcode_of(input int kind);
    case (kind)
      KLw:     return 7'b0000011;
      KSw:     return 7'b0100011;
      KR:      return 7'b0110011;
      KI:      return 7'b0010011;
      KBr:     return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock in a given phase; inputs change #1 after posedge, sampled at negedge.
  task automatic step(input int ph, input logic mr);
    mem_ready = mr;
    @(negedge clk);
    check($sformatf("ctrl ph%0d", ph), 64'(vec), 64'(phase_exp(ph, mr, zero, funct3)));
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    check({tag, " state"}, 64'(state_o), 64'(StFetch));
    check({tag, " retired"}, 64'(retired), 64'(exp_ret));
    check({tag, " illegal"}, 64'(illegal_instr), 64'(exp_ill));
    check({tag, " w4 retired"}, 64'(w_retired), 64'(exp_ret[3:0]));
  endtask

  task automatic run_instr(input int kind, input logic [2:0] f3, input logic z,
                           input int fs, input int ds);
    opcode = opcode_of(kind);
    funct3 = f3;
    zero   = z;
    repeat (fs) step(PhFetch, 1'b0);
    step(PhFetch, 1'b1);
    step(PhDecode, rbit());
    case (kind)
      KLw: begin
        step(PhMemAdr, rbit());
        repeat (ds) step(PhMemRead, 1'b0);
        step(PhMemRead, 1'b1);
        step(PhMemWb, rbit());
        exp_ret++;
      end
      KSw: begin
        step(PhMemAdr, rbit());
        repeat (ds) step(PhMemWrite, 1'b0);
        step(PhMemWrite, 1'b1);
        exp_ret++;
      end
      KR:  begin step(PhExecR, rbit()); step(PhAluWb, rbit()); exp_ret++; end
      KI:  begin step(PhExecI, rbit()); step(PhAluWb, rbit()); exp_ret++; end
      KJal: begin step(PhJal, rbit()); step(PhAluWb, rbit()); exp_ret++; end
      default: begin
        step(PhBranch, rbit());
        if (f3 == 3'd0 || f3 == 3'd1) exp_ret++;
        else exp_ill = 1'b1;
      end
    endcase
    end_checks($sformatf("kind%0d", kind));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset ctrl", 64'(vec), 64'd0);
    check("reset state", 64'(state_o), 64'(StFetch));
    check("reset retired", 64'(retired), 64'd0);
    check("reset illegal", 64'(illegal_instr), 64'd0);
    check("reset nj ctrl", 64'(n_vec), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_ret = '0;
    exp_ill = 1'b0;
  endtask

  initial begin
    logic [31:0] ret_before;
    do_reset();
    run_instr(KLw, 3'd0, 1'b0, 0, 0);

    // Reset while stalled in MEMREAD: nothing written, count cleared.
    opcode = opcode_of(KLw);
    step(PhFetch, 1'b1);
    step(PhDecode, 1'b0);
    step(PhMemAdr, 1'b0);
    step(PhMemRead, 1'b0);
    do_reset();
    end_checks("post midreset");
    run_instr(KLw, 3'd2, 1'b1, 0, 0);

    run_instr(KSw, 3'd0, 1'b0, 0, 3);
    run_instr(KBr, 3'd0, 1'b1, 0, 0);
    run_instr(KBr, 3'd1, 1'b1, 0, 0);
    run_instr(KR, 3'd5, 1'b0, 1, 0);
    run_instr(KI, 3'd3, 1'b1, 2, 0);

    // jal: main unit completes it; the JAL-disabled unit traps and holds.
    ret_before = exp_ret;
    run_instr(KJal, 3'd0, 1'b0, 0, 0);
    check("nj state", 64'(n_state), 64'(StTrap));
    check("nj illegal", 64'(n_illegal), 64'd1);
    check("nj retired", 64'(n_retired), 64'(ret_before));
    for (int i = 0; i < 3; i++) run_instr(KR, 3'($urandom_range(0, 7)), rbit(), 0, 0);
    check("nj hold state", 64'(n_state), 64'(StTrap));
    check("nj hold ctrl", 64'(n_vec), 64'd0);
    check("nj hold retired", 64'(n_retired), 64'(ret_before));
    do_reset();
    check("nj post reset state", 64'(n_state), 64'(StFetch));

    // 17 R-types: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++)
      run_instr(KR, 3'($urandom_range(0, 7)), rbit(), $urandom_range(0, 1), 0);
    check("wrap main", 64'(retired), 64'd17);
    check("wrap w4", 64'(w_retired), 64'd1);

    // Random mix, including stray-funct3 branches.
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [2:0] f3;
      k = $urandom_range(0, 4);
      if (k == 4 && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(2, 7));
      else if (k == 4) f3 = 3'($urandom_range(0, 1));
      else f3 = 3'($urandom_range(0, 7));
      run_instr(k, f3, rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Illegal opcode: trap and hold until reset.
    opcode = 7'b0010111;
    step(PhFetch, 1'b1);
    step(PhDecode, 1'b1);
    check("trap state", 64'(state_o), 64'(StTrap));
    check("trap illegal", 64'(illegal_instr), 64'd1);
    for (int i = 0; i < 4; i++) step(PhTrap, rbit());
    check("trap hold state", 64'(state_o), 64'(StTrap));
    check("trap retired", 64'(retired), 64'(exp_ret));
    do_reset();
    end_checks("final");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
